// File: rtl/ref_clk_gen_pkg.sv
// Shared types and default widths for the reference-clock generator.
// Imported by the top and by the NCO accumulator.
package ref_clk_gen_pkg;

    localparam int ACC_W_DEF = 8;
    localparam int CNT_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/ref_clk_gen_nco_accum.sv
// Phase accumulator with double-buffered tuning word.
// A new tuning word only takes effect on a period boundary, so retuning never shortens or stretches a half-cycle.
module nco_accum
    import ref_clk_gen_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             i_sys_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_stop_on_wrap,
    input  logic [ACC_W-1:0] i_ftw,
    input  logic             i_ftw_load,
    input  logic [ACC_W-1:0] i_jump_add,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_wrap,
    output logic             o_ftw_pending
);

    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_ftwActive;
    logic [ACC_W-1:0] r_ftwPend;
    logic             r_pend;
    logic [ACC_W+1:0] w_sum;
    logic             w_wrap;

    // Two guard bits so a jump plus the tuning word can overflow twice and still read as a single wrap.
    always_comb begin
        w_sum  = {2'b00, r_acc} + {2'b00, r_ftwActive} + {2'b00, i_jump_add};
        w_wrap = i_run && (w_sum[ACC_W+1:ACC_W] != 2'b00);
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (!i_run) begin
            r_acc <= '0;
        end else if (w_wrap && i_stop_on_wrap) begin
            r_acc <= '0;
        end else begin
            r_acc <= w_sum[ACC_W-1:0];
        end
    end

    // While stopped there is no period to protect, so a load goes straight to the active word.
    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_ftwActive <= '0;
            r_ftwPend   <= '0;
            r_pend      <= 1'b0;
        end else if (!i_run) begin
            if (i_ftw_load) begin
                r_ftwActive <= i_ftw;
                r_ftwPend   <= i_ftw;
                r_pend      <= 1'b0;
            end else if (r_pend) begin
                r_ftwActive <= r_ftwPend;
                r_pend      <= 1'b0;
            end
        end else begin
            if (w_wrap && r_pend) begin
                r_ftwActive <= r_ftwPend;
            end
            if (i_ftw_load) begin
                r_ftwPend <= i_ftw;
                r_pend    <= 1'b1;
            end else if (w_wrap) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign o_acc         = r_acc;
    assign o_wrap        = w_wrap;
    assign o_ftw_pending = r_pend;

endmodule

// File: rtl/ref_clk_gen.sv
// Programmable NCO reference-clock source for exercising PLL lock and re-lock.
// Holds the run/drain FSM, the phase-jump handshake and the completed-period counter.
module ref_clk_gen
    import ref_clk_gen_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_sys_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [ACC_W-1:0] i_ftw,
    input  logic             i_ftw_load,
    input  logic [ACC_W-1:0] i_phase_jump,
    input  logic             i_jump_req,
    output logic             o_jump_ack,
    output logic             o_ref_clk,
    output logic             o_period,
    output logic [CNT_W-1:0] o_period_cnt,
    output logic             o_ftw_pending,
    output logic             o_busy
);

    state_t           r_state;
    state_t           w_nextState;
    logic             r_ackPrev;
    logic             r_period;
    logic [CNT_W-1:0] r_periodCnt;
    logic             w_ack;
    logic             w_run;
    logic             w_stopOnWrap;
    logic             w_wrap;
    logic [ACC_W-1:0] w_jumpAdd;
    logic [ACC_W-1:0] w_acc;

    // A request is granted only if the previous cycle did not ack, forcing an ack-low gap between jumps.
    assign w_ack        = !i_rst && i_jump_req && !r_ackPrev;
    assign w_jumpAdd    = (w_ack && (r_state == RUN)) ? i_phase_jump : '0;
    assign w_run        = (r_state != IDLE);
    assign w_stopOnWrap = (r_state == DRAIN) && !i_en;

    nco_accum #(
        .ACC_W(ACC_W)
    ) u_nco (
        .i_sys_clk     (i_sys_clk),
        .i_rst         (i_rst),
        .i_run         (w_run),
        .i_stop_on_wrap(w_stopOnWrap),
        .i_ftw         (i_ftw),
        .i_ftw_load    (i_ftw_load),
        .i_jump_add    (w_jumpAdd),
        .o_acc         (w_acc),
        .o_wrap        (w_wrap),
        .o_ftw_pending (o_ftw_pending)
    );

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Draining finishes the current period so the output never emits a runt high pulse.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (i_en) w_nextState = RUN;
            RUN:     if (!i_en) w_nextState = DRAIN;
            DRAIN: begin
                if (i_en) begin
                    w_nextState = RUN;
                end else if (w_wrap) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk) begin
        if (i_rst) begin
            r_ackPrev   <= 1'b0;
            r_period    <= 1'b0;
            r_periodCnt <= '0;
        end else begin
            r_ackPrev <= w_ack;
            r_period  <= w_wrap;
            if (w_wrap) begin
                r_periodCnt <= r_periodCnt + CNT_W'(1);
            end
        end
    end

    assign o_jump_ack   = w_ack;
    assign o_ref_clk    = w_acc[ACC_W-1];
    assign o_period     = r_period;
    assign o_period_cnt = r_periodCnt;
    assign o_busy       = (r_state != IDLE);

endmodule
